// File: rtl/int_to_fp_conv.sv
// 32-bit signed/unsigned integer to IEEE 754 single-precision converter.
// Normalises one bit per cycle and rounds to nearest, ties to even.
module int_to_fp_conv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        sign;
    logic [31:0] mag;
    logic [7:0]  exp;
    logic        accept;
    logic        neg_in;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_sum;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign neg_in    = in_signed && in_data[31];

    // mag[31] is the hidden bit; bit 8 is the mantissa lsb
    assign guard    = mag[7];
    assign sticky   = |mag[6:0];
    assign round_up = guard && (sticky || mag[8]);
    assign mant_sum = {1'b0, mag[30:8]} + {23'd0, round_up};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = NORM;
            NORM:    if (mag == '0 || mag[31]) state_nx = (mag == '0) ? DONE : ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign        <= 1'b0;
            mag         <= '0;
            exp         <= '0;
            out_data    <= '0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign <= neg_in;
                        mag  <= neg_in ? (32'd0 - in_data) : in_data;
                        exp  <= 8'd158;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        out_data    <= '0;
                        out_inexact <= 1'b0;
                    end else if (!mag[31]) begin
                        mag <= {mag[30:0], 1'b0};
                        exp <= exp - 8'd1;
                    end
                end
                ROUND: begin
                    // a mantissa carry leaves mant_sum[22:0] all zero, so only exp needs bumping
                    out_data    <= {sign, exp + {7'd0, mant_sum[23]}, mant_sum[22:0]};
                    out_inexact <= guard || sticky;
                end
                default: ;
            endcase
        end
    end

endmodule
